// File: rtl/cr_osf_ob_stats_accum_pkg.sv
// cr_osfPKG: shared types and constants for the OSF outbound statistics block.
// Holds the per-cycle event structure produced by the outbound support logic,
// the counter index enumeration used by the register read port and the
// default counter widths.
package cr_osfPKG;

  localparam int OSF_OB_BYTE_CNT_W = 48;
  localparam int OSF_OB_EVT_CNT_W  = 32;
  localparam int OSF_OB_RD_W       = 48;
  localparam int OSF_OB_NUM_EVT    = 6;
  localparam int OSF_OB_NUM_CNT    = 7;

  // Read-port counter indices.
  typedef enum logic [2:0] {
    OSF_OB_CNT_BYTES     = 3'd0,
    OSF_OB_CNT_FRAMES    = 3'd1,
    OSF_OB_CNT_CQE       = 3'd2,
    OSF_OB_CNT_DAT_STALL = 3'd3,
    OSF_OB_CNT_PDT_STALL = 3'd4,
    OSF_OB_CNT_SYS_BP    = 3'd5,
    OSF_OB_CNT_OB_STALL  = 3'd6,
    OSF_OB_CNT_RSVD      = 3'd7
  } osf_ob_cnt_idx_e;

  // Per-cycle outbound event bits from the support logic.
  typedef struct packed {
    logic [3:0] rsvd;
    logic       dat_fifo_stall;
    logic       pdt_fifo_stall;
    logic       ob_sys_bp;
    logic       ob_stall;
  } osf_stats_t;

endpackage

// File: rtl/cr_osf_ob_stats_accum_cntr.sv
// cr_osf_ob_cntr: one live statistics counter with its snapshot shadow.
// The live counter adds the already-registered increment each cycle. On a
// snapshot the shadow captures the live-next value (live plus the increment
// in flight), so nothing straddling the snapshot edge is lost; with clear the
// live counter restarts from zero instead of from live-next, so that same
// increment is not counted again in the next period.
// Build option CR_OSF_OB_CNT_SAT_EN: saturate at all-ones with a sticky flag
// (cleared only by a clearing snapshot); otherwise wrap modulo 2^CNT_W and
// tie the flag low.
module cr_osf_ob_cntr #(
  parameter int CNT_W = 32,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_vld,
  input  logic [INC_W-1:0] inc_amt,
  input  logic             snap,
  input  logic             clr,
  output logic [CNT_W-1:0] shadow,
  output logic             sat
);

  logic [CNT_W-1:0] r_live;
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] w_inc;
  logic [CNT_W-1:0] w_live_nxt;

  assign w_inc = inc_vld ? CNT_W'(inc_amt) : '0;

`ifdef CR_OSF_OB_CNT_SAT_EN

  logic [CNT_W:0] w_sum;
  logic           w_ovf;
  logic           r_sat;

  // Add with one guard bit so the carry-out flags an overflow.
  function automatic logic [CNT_W:0] add_wide(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Fold a guarded sum back to counter width, pinning at all-ones on overflow.
  function automatic logic [CNT_W-1:0] sat_fold(input logic [CNT_W:0] s);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign w_sum      = add_wide(r_live, w_inc);
  assign w_ovf      = w_sum[CNT_W];
  assign w_live_nxt = sat_fold(w_sum);

  // Sticky overflow flag; only a clearing snapshot (which also zeroes the
  // counter) may release it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (snap && clr) begin
      r_sat <= 1'b0;
    end else if (w_ovf) begin
      r_sat <= 1'b1;
    end
  end

  assign sat = r_sat;

`else

  assign w_live_nxt = r_live + w_inc;
  assign sat        = 1'b0;

`endif

  // Live accumulation and snapshot capture / optional clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= '0;
      r_shadow <= '0;
    end else if (snap) begin
      r_shadow <= w_live_nxt;
      r_live   <= clr ? '0 : w_live_nxt;
    end else begin
      r_live   <= w_live_nxt;
    end
  end

  assign shadow = r_shadow;

endmodule

// File: rtl/cr_osf_ob_stats_accum.sv
// cr_osf_ob_stats_accum: outbound statistics accumulator.
// Registers the per-cycle byte/frame/CQE/event strobes once (stage p1), then
// feeds seven independent counters (bytes plus six single-bit events). A
// single-cycle snap_req captures every counter into its shadow in the same
// edge (optionally clearing the live counters); the read port only ever
// returns shadows, registered one cycle after rd_req.
// Build option CR_OSF_OB_CNT_SAT_EN: counters saturate and report sticky
// per-counter saturation on sat_status; undefined, counters wrap and
// sat_status reads 0.
module cr_osf_ob_stats_accum
  import cr_osfPKG::*;
#(
  parameter int BYTE_CNT_W = OSF_OB_BYTE_CNT_W,
  parameter int EVT_CNT_W  = OSF_OB_EVT_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ob_bytes_cnt_stb,
  input  logic [3:0]  ob_bytes_cnt_amt,
  input  logic        ob_frame_cnt_stb,
  input  logic        osf_sup_cqe_exit,
  input  osf_stats_t  osf_stat_events,
  input  logic        snap_req,
  input  logic        snap_clr,
  output logic        snap_ack,
  input  logic        rd_req,
  input  logic [2:0]  rd_sel,
  output logic        rd_ack,
  output logic [47:0] rd_data,
  output logic [6:0]  sat_status
);

  // Event vector bit k feeds counter index k+1.
  logic [OSF_OB_NUM_EVT-1:0] w_evt_p0;
  logic                      w_unused_rsvd;

  logic                      r_byte_stb_p1;
  logic [3:0]                r_byte_amt_p1;
  logic [OSF_OB_NUM_EVT-1:0] r_evt_p1;

  logic                      w_snap;
  logic                      w_clr;

  logic [BYTE_CNT_W-1:0]     w_byte_shadow;
  logic                      w_byte_sat;
  logic [EVT_CNT_W-1:0]      w_evt_shadow [OSF_OB_NUM_EVT];
  logic [OSF_OB_NUM_EVT-1:0] w_evt_sat;

  logic [OSF_OB_RD_W-1:0]    w_rd_mux;

  logic                      r_snap_ack;
  logic                      r_rd_ack;
  logic [OSF_OB_RD_W-1:0]    r_rd_data;

  assign w_evt_p0 = {osf_stat_events.ob_stall,
                     osf_stat_events.ob_sys_bp,
                     osf_stat_events.pdt_fifo_stall,
                     osf_stat_events.dat_fifo_stall,
                     osf_sup_cqe_exit,
                     ob_frame_cnt_stb};

  assign w_unused_rsvd = ^osf_stat_events.rsvd;

  // ---- p0 -> p1: register all increment inputs once ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_stb_p1 <= 1'b0;
      r_byte_amt_p1 <= '0;
      r_evt_p1      <= '0;
    end else begin
      r_byte_stb_p1 <= ob_bytes_cnt_stb;
      r_byte_amt_p1 <= ob_bytes_cnt_amt;
      r_evt_p1      <= w_evt_p0;
    end
  end

  // Snapshot is not delayed: it acts on the edge ending the request cycle, so
  // the increment sitting in p1 lands in the closing period.
  assign w_snap = snap_req;
  assign w_clr  = snap_req & snap_clr;

  // ---- p1 -> counters: live accumulate, shadow capture ----
  cr_osf_ob_cntr #(
    .CNT_W (BYTE_CNT_W),
    .INC_W (4)
  ) u_cntr_bytes (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_vld (r_byte_stb_p1),
    .inc_amt (r_byte_amt_p1),
    .snap    (w_snap),
    .clr     (w_clr),
    .shadow  (w_byte_shadow),
    .sat     (w_byte_sat)
  );

  for (genvar g = 0; g < OSF_OB_NUM_EVT; g++) begin : g_evt_cntr
    cr_osf_ob_cntr #(
      .CNT_W (EVT_CNT_W),
      .INC_W (1)
    ) u_cntr_evt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_vld (r_evt_p1[g]),
      .inc_amt (1'b1),
      .snap    (w_snap),
      .clr     (w_clr),
      .shadow  (w_evt_shadow[g]),
      .sat     (w_evt_sat[g])
    );
  end

  // Select the requested shadow, zero-extended to the read width.
  always_comb begin
    w_rd_mux = '0;
    case (osf_ob_cnt_idx_e'(rd_sel))
      OSF_OB_CNT_BYTES:     w_rd_mux = OSF_OB_RD_W'(w_byte_shadow);
      OSF_OB_CNT_FRAMES:    w_rd_mux = OSF_OB_RD_W'(w_evt_shadow[0]);
      OSF_OB_CNT_CQE:       w_rd_mux = OSF_OB_RD_W'(w_evt_shadow[1]);
      OSF_OB_CNT_DAT_STALL: w_rd_mux = OSF_OB_RD_W'(w_evt_shadow[2]);
      OSF_OB_CNT_PDT_STALL: w_rd_mux = OSF_OB_RD_W'(w_evt_shadow[3]);
      OSF_OB_CNT_SYS_BP:    w_rd_mux = OSF_OB_RD_W'(w_evt_shadow[4]);
      OSF_OB_CNT_OB_STALL:  w_rd_mux = OSF_OB_RD_W'(w_evt_shadow[5]);
      default:              w_rd_mux = '0;
    endcase
  end

  // ---- response stage: snapshot ack and registered read data ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_ack <= 1'b0;
      r_rd_ack   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_snap_ack <= snap_req;
      r_rd_ack   <= rd_req;
      if (rd_req) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign snap_ack   = r_snap_ack;
  assign rd_ack     = r_rd_ack;
  assign rd_data    = r_rd_data;
  assign sat_status = {w_evt_sat, w_byte_sat};

endmodule

// File: doc/cr_osf_ob_stats_accum.md
# cr_osf_ob_stats_accum

Accumulates the per-cycle outbound statistics strobes and event pulses from the OSF outbound support logic into wide counters. It provides an atomic snapshot/clear handshake and a registered read port for the OSF register block. It sits directly downstream of the outbound parser/support stage and upstream of the `cr_osf_regs` read path. It is purely an observer and applies no backpressure to the datapath.

## Interface
Parameters:
- `BYTE_CNT_W`, default 48: byte counter width.
- `EVT_CNT_W`, default 32: width of the frame, CQE and event counters.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ob_bytes_cnt_stb`  in  1  byte-count increment strobe.
- `ob_bytes_cnt_amt`  in  4  bytes to add (0..8 nominal; any 0..15 is added as given).
- `ob_frame_cnt_stb`  in  1  one outbound frame started.
- `osf_sup_cqe_exit`  in  1  one CQE completed.
- `osf_stat_events`  in  `osf_stats_t`  per-cycle event bits; uses `dat_fifo_stall`, `pdt_fifo_stall`, `ob_sys_bp` and `ob_stall`, ignores `rsvd`.
- `snap_req`  in  1  single-cycle snapshot request.
- `snap_clr`  in  1  qualifies `snap_req`: clear the live counters on snapshot.
- `snap_ack`  out  1  pulse when the snapshot is complete.
- `rd_req`  in  1  single-cycle read request.
- `rd_sel`  in  3  counter index.
- `rd_ack`  out  1  read-data-valid pulse.
- `rd_data`  out  48  selected shadow counter, zero-extended.
- `sat_status`  out  7  per-counter sticky saturation flags.

## Operation
- Counter indices:
  - 0: bytes (`BYTE_CNT_W`).
  - 1: frames.
  - 2: CQE exits.
  - 3: `dat_fifo_stall` cycles.
  - 4: `pdt_fifo_stall` cycles.
  - 5: `ob_sys_bp` cycles.
  - 6: `ob_stall` cycles.
  - 7: reserved, reads 0.
- Input stage: all increment inputs are registered once (stage S1).
- Live counters add the S1 increments on the next edge:
  - bytes += amt when the byte strobe is set;
  - every other counter += 1 when its bit is set.
- All counters update independently in the same cycle; simultaneous events never interact.
- Snapshot on `snap_req`:
  - each shadow register takes live + S1 increment (the live-next value);
  - when `snap_clr`=1, live counters load 0 and that S1 increment is not double-counted;
  - when `snap_clr`=0, live counters continue from live-next.
- Partition rule: strobes at cycles ≤ S−1 are in snapshot S; strobes at cycle ≥ S belong to the next period. No event is ever lost or counted twice.
- `snap_req` while a prior `snap_ack` is still pending cannot occur; the snapshot is a single cycle. Back-to-back `snap_req` on consecutive cycles is legal; each is processed independently.
- Reads:
  - `rd_data` returns the shadow register for `rd_sel` and never the live counter;
  - `rd_sel` 7 returns 0.
- A read coincident with `snap_req` returns the old shadow value.
- Reset mid-operation: every counter, shadow, S1 stage and flag is cleared asynchronously; events pending in S1 are discarded.

## Timing
- Reset values: `snap_ack`=0, `rd_ack`=0, `rd_data`=0, `sat_status`=0; all counters and shadows 0.
- Event latency: a strobe at cycle N reaches S1 at N+1 and the live counter at N+2.
- Snapshot: `snap_req` at cycle S updates the shadows at the S/S+1 edge; `snap_ack` is high for exactly cycle S+1.
- Read: `rd_req` at cycle R gives `rd_data` registered and valid with a `rd_ack` pulse at R+1. `rd_data` holds until the next `rd_ack`.
- `rd_req` on consecutive cycles is supported, one result per cycle.

## Configuration
- `CR_OSF_OB_CNT_SAT_EN` defined:
  - each counter saturates at all-ones; an increment that would overflow leaves all-ones;
  - the matching `sat_status` bit is set sticky;
  - `sat_status` bits clear only on a `snap_req` with `snap_clr`=1 (which also zeroes the counter).
- `CR_OSF_OB_CNT_SAT_EN` undefined:
  - counters wrap modulo 2^W;
  - `sat_status` is tied to 0.

## Structure
- `cr_osfPKG` holds:
  - the `osf_ob_cnt_idx_e` enum (indices 0..7);
  - the `OSF_OB_BYTE_CNT_W` and `OSF_OB_EVT_CNT_W` constants.
- `osf_stats_t` remains in the existing package, unchanged.
- One natural sub-module, `cr_osf_ob_cntr`:
  - parameters: width and increment width;
  - function: live counter, shadow capture/clear and saturation logic;
  - instantiated 7 times.

## Test plan
- Ten byte strobes with amt 8, then `snap_req` → `snap_ack` at S+1; read idx 0 returns 80; read idx 1 returns the frame-strobe count.
- Strobe at S−1 and at S, with `snap_req`+`snap_clr` at S → snapshot includes only the S−1 strobe; a second snapshot includes only the S strobe.
- All six event inputs high for 100 cycles, then snapshot → idx 2..6 each read 100; idx 7 reads 0.
- Preload a frame counter to 0xFFFFFFFE via 2^32−2 strobes (or force), then 3 more strobes:
  - with `CR_OSF_OB_CNT_SAT_EN`: reads 0xFFFFFFFF and `sat_status[1]`=1;
  - without: reads 1.
- `rd_req` at the same cycle as `snap_req` → old value returned; the following read returns the new value.
- Assert `rst_n` low mid-stream with strobes in S1 → all outputs 0; the post-reset snapshot reads 0 for every index.
